div_iter_unit: RTL and testbench

- Multi-cycle radix-2 restoring divider. It is the responder side of the EX-stage divide handshake (start/annul/ready).
- EX asserts start with operands and stalls the pipeline while ready is low. It deasserts start once ready is seen.
- Produces a 64-bit result {remainder, quotient} for DIV/DIVU, later written to HI/LO.

---
 rtl/div_iter_unit_if.sv | 26 ++
 rtl/div_iter_unit.sv | 136 +++++++++++++
 tb/tb_div_iter_unit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/div_iter_unit_if.sv
// EX-stage divide handshake bundle: EX drives operands and start/annul,
// the divider answers with ready and the {remainder, quotient} result.
interface div_iter_unit_if #(
  parameter int DATA_W = 32
);
  // start_i is a request held high by EX until it sees ready_o; ready_o is
  // registered and high only while a result is presented; EX completes the
  // transfer by dropping start_i, and annul_i aborts an operation in flight.
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_iter_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; one quotient bit per
// cycle on magnitudes, sign fixed up on completion. Result is {rem, quo}.
module div_iter_unit #(
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  div_iter_unit_if.slave div_if,
  output logic [1:0]     state_o
);
  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2*DATA_W:0]     dividend_q, dividend_d;
  logic [DATA_W-1:0]     divisor_q, divisor_d;
  logic                  neg_quo_q, neg_quo_d;
  logic                  neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;

  logic [2*DATA_W:0]     shifted;
  logic [DATA_W:0]       diff;
  logic [DATA_W-1:0]     abs_op1, abs_op2, quo, rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FREE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  // BYZERO dwells two edges so a zero divisor reports ready two edges after
  // the start edge; annul has priority over completion in the busy states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FREE: begin
        if (div_if.start_i && !div_if.annul_i)
          state_d = (div_if.opdata2_i == '0) ? S_BYZERO : S_ON;
      end
      S_BYZERO: begin
        if (div_if.annul_i)            state_d = S_FREE;
        else if (cnt_q == CW'(1))      state_d = S_END;
      end
      S_ON: begin
        if (div_if.annul_i)            state_d = S_FREE;
        else if (cnt_q == CW'(DATA_W)) state_d = S_END;
      end
      S_END: begin
        if (!div_if.start_i)           state_d = S_FREE;
      end
      default: state_d = S_FREE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    result_d   = '0;
    ready_d    = (state_d == S_END);

    shifted = dividend_q << 1;
    diff    = shifted[2*DATA_W:DATA_W] - {1'b0, divisor_q};
    quo     = neg_quo_q ? -dividend_q[DATA_W-1:0] : dividend_q[DATA_W-1:0];
    rem     = neg_rem_q ? -dividend_q[2*DATA_W-1:DATA_W]
                        : dividend_q[2*DATA_W-1:DATA_W];
    // Magnitude of the most negative value wraps to itself, read as 2^(W-1).
    abs_op1 = (div_if.signed_div_i && div_if.opdata1_i[DATA_W-1])
              ? -div_if.opdata1_i : div_if.opdata1_i;
    abs_op2 = (div_if.signed_div_i && div_if.opdata2_i[DATA_W-1])
              ? -div_if.opdata2_i : div_if.opdata2_i;

    case (state_q)
      S_FREE: begin
        if (state_d == S_ON) begin
          divisor_d  = abs_op2;
          dividend_d = {{(DATA_W+1){1'b0}}, abs_op1};
          neg_quo_d  = div_if.signed_div_i &
                       (div_if.opdata1_i[DATA_W-1] ^ div_if.opdata2_i[DATA_W-1]);
          neg_rem_d  = div_if.signed_div_i & div_if.opdata1_i[DATA_W-1];
          cnt_d      = '0;
        end else if (state_d == S_BYZERO) begin
          cnt_d = '0;
        end
      end
      S_BYZERO: begin
        cnt_d = (state_d == S_BYZERO) ? cnt_q + CW'(1) : '0;
      end
      S_ON: begin
        if (state_d == S_ON) begin
          dividend_d = diff[DATA_W] ? shifted
                                    : {diff, shifted[DATA_W-1:1], 1'b1};
          cnt_d      = cnt_q + CW'(1);
        end else begin
          cnt_d = '0;
          if (state_d == S_END) result_d = {rem, quo};
        end
      end
      S_END: begin
        if (state_d == S_END) result_d = result_q;
        else                  cnt_d    = '0;
      end
      default: ;
    endcase
  end

  assign div_if.result_o = result_q;
  assign div_if.ready_o  = ready_q;
  assign state_o         = state_q;
endmodule

// File: tb/tb_div_iter_unit.sv
// Directed and reference-model checks of div_iter_unit: latency, signed and
// unsigned results, divide-by-zero, annul, mid-operation reset, END hold.
module tb_div_iter_unit;
  localparam int DATA_W = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_dbg;

  div_iter_unit_if #(.DATA_W(DATA_W)) dif ();

  div_iter_unit #(.DATA_W(DATA_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .div_if  (dif),
    .state_o (state_dbg)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference: plain 64-bit arithmetic, truncating division.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check64(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Cycle model: what ready/result must be, from handshake rules only.
  logic [63:0] exp_q[$];
  logic        exp_ready  = 1'b0;
  logic [63:0] exp_result = '0;
  int          m_phase    = 0;
  int          m_left     = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase    <= 0;
      m_left     <= 0;
      exp_ready  <= 1'b0;
      exp_result <= '0;
      exp_q.delete();
    end else begin
      case (m_phase)
        0: if (dif.start_i && !dif.annul_i) begin
          exp_q.push_back(ref_div(dif.signed_div_i, dif.opdata1_i, dif.opdata2_i));
          m_left  <= (dif.opdata2_i == 32'd0) ? 2 : DATA_W + 1;
          m_phase <= 1;
        end
        1: if (dif.annul_i) begin
          m_phase <= 0;
          void'(exp_q.pop_front());
        end else if (m_left == 1) begin
          m_phase    <= 2;
          exp_ready  <= 1'b1;
          exp_result <= exp_q.pop_front();
        end else begin
          m_left <= m_left - 1;
        end
        default: if (!dif.start_i) begin
          m_phase    <= 0;
          exp_ready  <= 1'b0;
          exp_result <= '0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    n_vec++;
    if (dif.ready_o !== exp_ready || dif.result_o !== exp_result) begin
      n_err++;
      $display("FAIL cycle_cmp t=%0t: ready %b result %h expected ready %b result %h",
               $time, dif.ready_o, dif.result_o, exp_ready, exp_result);
    end
  end

  task automatic drive_start(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    dif.signed_div_i = s;
    dif.opdata1_i    = a;
    dif.opdata2_i    = b;
    dif.start_i      = 1'b1;
  endtask

  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input int exp_lat, input logic [63:0] exp_res,
                         input string name);
    int   lat;
    logic got;
    drive_start(s, a, b);
    @(posedge clk);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (dif.ready_o === 1'b1) got = 1'b1;
    end
    check64({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check64({name, "_result"}, dif.result_o, exp_res);
    dif.opdata1_i = $urandom;
    dif.opdata2_i = $urandom;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    if (hold > 0) check64({name, "_hold"}, {dif.result_o[62:0], dif.ready_o}, {exp_res[62:0], 1'b1});
    dif.start_i = 1'b0;
    @(posedge clk); #1;
    check64({name, "_drop"}, {dif.result_o, 1'b0} | 65'(dif.ready_o), 65'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = '0;
    dif.opdata2_i    = '0;
    dif.start_i      = 1'b0;
    dif.annul_i      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check64("reset_state", {dif.result_o[62:0], dif.ready_o}, 64'd0);
    rst = 1'b0;

    // Pin the reference model with hand-computed values.
    check64("ref_100_7",   ref_div(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
    check64("ref_m7_2",    ref_div(1'b1, 32'hFFFFFFF9, 32'd2), {32'hFFFFFFFF, 32'hFFFFFFFD});
    check64("ref_min_m1",  ref_div(1'b1, 32'h80000000, 32'hFFFFFFFF), {32'd0, 32'h80000000});

    run_div(1'b0, 32'd100, 32'd7, 0, 33, {32'd2, 32'd14}, "u_100_7");
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, 0, 33, {32'hFFFFFFFF, 32'hFFFFFFFD}, "s_m7_2");
    run_div(1'b1, 32'd7, 32'hFFFFFFFE, 0, 33, {32'h00000001, 32'hFFFFFFFD}, "s_7_m2");
    run_div(1'b0, 32'hFFFFFFF9, 32'd2, 0, 33, {32'h00000001, 32'h7FFFFFFC}, "u_big_2");
    run_div(1'b1, 32'd12345, 32'd0, 0, 2, 64'd0, "s_byzero");
    run_div(1'b0, 32'd12345, 32'd0, 0, 2, 64'd0, "u_byzero");

    // Annul once ten quotient bits have been produced.
    drive_start(1'b0, 32'd100, 32'd7);
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    dif.annul_i = 1'b1;
    dif.start_i = 1'b0;
    @(posedge clk); #1;
    dif.annul_i = 1'b0;
    repeat (3) begin
      check64("annul_idle", {dif.result_o[62:0], dif.ready_o}, 64'd0);
      @(posedge clk); #1;
    end
    run_div(1'b0, 32'd20, 32'd3, 0, 33, {32'd2, 32'd6}, "annul_restart");

    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 5, 33, {32'd0, 32'h80000000}, "s_min_m1");

    // Synchronous reset in the middle of an operation.
    drive_start(1'b1, 32'd1000, 32'd9);
    @(posedge clk);
    repeat (20) @(posedge clk);
    #1;
    rst         = 1'b1;
    dif.start_i = 1'b0;
    @(posedge clk); #1;
    check64("midop_reset", {dif.result_o[62:0], dif.ready_o}, 64'd0);
    rst = 1'b0;
    run_div(1'b1, 32'd1000, 32'd9, 0, 33, {32'd1, 32'd111}, "after_reset");

    for (int i = 0; i < 12; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = (i == 5) ? 32'd0 : $urandom >> $urandom_range(0, 30);
      run_div(rs, ra, rb, $urandom_range(0, 2), (rb == 32'd0) ? 2 : 33,
              ref_div(rs, ra, rb), "random");
    end

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
